fp_div_recip_mul: RTL and testbench



---
 rtl/fpu_div_pkg.sv | 46 ++++
 rtl/fp_div_fifo.sv | 68 ++++++
 rtl/fp_div_recip_mul.sv | 216 +++++++++++++++++++++
 tb/tb_fp_div_recip_mul.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the reciprocal-multiply divider.
// Latency: n/a (types, constants and a pure classification function only).
// Backpressure: n/a.
package fpu_div_pkg;

   localparam int          DEF_RECIP_LAT  = 4;
   localparam int          DEF_FIFO_DEPTH = 8;
   localparam int          SP_EXP_W       = 8;
   localparam int          SP_MAN_W       = 23;
   localparam logic [31:0] QNAN           = 32'h7FC0_0000;

   // Operand class flags; subnormals classify as zero.
   typedef struct packed {
      logic nan;
      logic inf;
      logic zero;
   } cls_t;

   // One delay-line slot: everything about the dividend the multiplier needs,
   // plus both operand classes so specials can be resolved without recip_i.
   typedef struct packed {
      logic                vld;
      logic                sign;
      logic [SP_EXP_W-1:0] exp_a;
      logic [SP_MAN_W-1:0] man_a;
      cls_t                cls_a;
      cls_t                cls_b;
   } dly_ent_t;

   typedef enum logic [1:0] {
      SPC_NONE,
      SPC_NAN,
      SPC_INF,
      SPC_ZERO
   } spc_e;

   function automatic cls_t classify(input logic [SP_EXP_W-1:0] e,
                                     input logic [SP_MAN_W-1:0] m);
      cls_t c;
      c.nan  = (&e) && (|m);
      c.inf  = (&e) && !(|m);
      c.zero = (e == '0);
      return c;
   endfunction

endpackage

// File: rtl/fp_div_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible at dat_o/vld_o the cycle after the push edge.
// Backpressure: pop on empty is ignored; push on full is dropped unless a pop frees the slot.
// Ports: push_i/push_dat_i write side, pop_i read strobe, vld_o/dat_o head, count_o occupancy.
module fp_div_fifo
   import fpu_div_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] push_dat_i,
   input  logic          pop_i,
   output logic          vld_o,
   output logic [DW-1:0] dat_o,
   output logic [CW-1:0] count_o
);

   localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
         end else if (!do_push && do_pop) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   // Storage needs no reset: nothing is read unless count_q says it was written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   assign vld_o   = (count_q != '0);
   // Gate the head so the output reads zero whenever nothing is buffered.
   assign dat_o   = vld_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/fp_div_recip_mul.sv
// Single-precision q = a / b computed as a * recip(b) from an external reciprocal stage.
// Latency: pair accepted at edge 0 is pushed into the output FIFO at edge RECIP_LAT+2.
// Backpressure: credit-based in_ready keeps the FIFO from overflowing; the pipeline itself never stalls.
// Ports: in_valid/in_ready/a/b operand handshake, div_o divisor to the reciprocal stage,
//        recip_i its result RECIP_LAT edges later, out_valid/out_ready/q result handshake.
// Option: define FP_DIV_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_div_recip_mul
   import fpu_div_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int EXP_WIDTH  = 8,
   parameter int MAN_WIDTH  = 23,
   parameter int BIAS       = 127,
   parameter int RECIP_LAT  = DEF_RECIP_LAT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH   // must be >= RECIP_LAT+2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] div_o,
   input  logic [WIDTH-1:0] recip_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = CW + 1;
   localparam int PW = 2 * (MAN_WIDTH + 1);   // full significand product width
   localparam int XW = EXP_WIDTH + 2;         // signed exponent with overflow headroom
`ifdef FP_DIV_RNE_EN
   localparam int PK = PW;                    // rounding needs every dropped bit
`else
   localparam int PK = MAN_WIDTH + 2;         // truncation only needs the top bits
`endif
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_WIDTH) - 1);
   localparam logic signed [XW-1:0] EXP_MIN = XW'(0);

   logic                  acc;
   logic [CW-1:0]         fifo_cnt;
   logic [CW-1:0]         inflight_q;
   dly_ent_t              in_ent;
   dly_ent_t              dly_q [RECIP_LAT];
   dly_ent_t              ent_out;

   logic                  m1_vld_q;
   logic                  m1_sign_q;
   logic [PK-1:0]         m1_prod_d, m1_prod_q;
   logic signed [XW-1:0]  m1_exp_d, m1_exp_q;
   spc_e                  m1_spc_d, m1_spc_q;

   logic [MAN_WIDTH-1:0]  man_n, man_r;
   logic signed [XW-1:0]  exp_n, exp_r;
   logic [WIDTH-1:0]      m2_res_d, m2_res_q;
   logic                  m2_vld_q;

   // The quotient sign comes from the operands; the reciprocal's own sign is redundant.
   logic                  unused_recip_sign;
   assign unused_recip_sign = recip_i[WIDTH-1];

   // ---------------- input side ----------------
   // Only registered counts feed in_ready, so a pop in this cycle frees nothing yet.
   assign in_ready = (SW'(fifo_cnt) + SW'(inflight_q)) < SW'(FIFO_DEPTH);
   assign acc      = in_valid && in_ready;
   assign div_o    = acc ? b : '0;

   always_comb begin
      in_ent = '0;
      if (acc) begin
         in_ent.vld   = 1'b1;
         in_ent.sign  = a[WIDTH-1] ^ b[WIDTH-1];
         in_ent.exp_a = a[WIDTH-2 -: EXP_WIDTH];
         in_ent.man_a = a[MAN_WIDTH-1:0];
         in_ent.cls_a = classify(a[WIDTH-2 -: EXP_WIDTH], a[MAN_WIDTH-1:0]);
         in_ent.cls_b = classify(b[WIDTH-2 -: EXP_WIDTH], b[MAN_WIDTH-1:0]);
      end
   end

   // Delay line shifts every cycle; idle cycles insert bubbles so the exit
   // stays lock-step with recip_i.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RECIP_LAT; i++) dly_q[i] <= '0;
      end else begin
         dly_q[0] <= in_ent;
         for (int i = 1; i < RECIP_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   assign ent_out = dly_q[RECIP_LAT-1];

   // ---------------- M1: multiply and exponent sum ----------------
   always_comb begin
      m1_prod_d = PK'((PW'({1'b1, ent_out.man_a}) * PW'({1'b1, recip_i[MAN_WIDTH-1:0]}))
                      >> (PW - PK));
      m1_exp_d  = XW'(ent_out.exp_a) + XW'(recip_i[WIDTH-2 -: EXP_WIDTH]) - XW'(BIAS);
      m1_spc_d  = SPC_NONE;
      if (ent_out.cls_a.nan || ent_out.cls_b.nan ||
          (ent_out.cls_a.zero && ent_out.cls_b.zero) ||
          (ent_out.cls_a.inf && ent_out.cls_b.inf)) begin
         m1_spc_d = SPC_NAN;
      end else if (ent_out.cls_a.inf || ent_out.cls_b.zero) begin
         m1_spc_d = SPC_INF;
      end else if (ent_out.cls_a.zero || ent_out.cls_b.inf) begin
         m1_spc_d = SPC_ZERO;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m1_vld_q  <= 1'b0;
         m1_sign_q <= 1'b0;
         m1_prod_q <= '0;
         m1_exp_q  <= '0;
         m1_spc_q  <= SPC_NONE;
      end else begin
         m1_vld_q  <= ent_out.vld;
         m1_sign_q <= ent_out.sign;
         m1_prod_q <= m1_prod_d;
         m1_exp_q  <= m1_exp_d;
         m1_spc_q  <= m1_spc_d;
      end
   end

   // ---------------- M2: normalize, round, range check, specials ----------------
   always_comb begin
      // Product lies in [1,4); the top bit decides the one-place normalization.
      if (m1_prod_q[PK-1]) begin
         man_n = m1_prod_q[PK-2 -: MAN_WIDTH];
         exp_n = m1_exp_q + XW'(1);
      end else begin
         man_n = m1_prod_q[PK-3 -: MAN_WIDTH];
         exp_n = m1_exp_q;
      end
   end

`ifdef FP_DIV_RNE_EN
   logic                 grd;
   logic                 stk;
   logic                 rnd_inc;
   logic [MAN_WIDTH:0]   man_sum;

   always_comb begin
      if (m1_prod_q[PK-1]) begin
         grd = m1_prod_q[PK-2-MAN_WIDTH];
         stk = |m1_prod_q[PK-3-MAN_WIDTH:0];
      end else begin
         grd = m1_prod_q[PK-3-MAN_WIDTH];
         stk = |m1_prod_q[PK-4-MAN_WIDTH:0];
      end
      rnd_inc = grd && (stk || man_n[0]);
      man_sum = {1'b0, man_n} + (MAN_WIDTH + 1)'(rnd_inc);
      // A carry out means the mantissa wrapped to 1.0 of the next binade.
      man_r   = man_sum[MAN_WIDTH-1:0];
      exp_r   = man_sum[MAN_WIDTH] ? exp_n + XW'(1) : exp_n;
   end
`else
   always_comb begin
      man_r = man_n;
      exp_r = exp_n;
   end
`endif

   always_comb begin
      m2_res_d = {m1_sign_q, exp_r[EXP_WIDTH-1:0], man_r};
      if (exp_r >= EXP_MAX) begin
         m2_res_d = {m1_sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      end else if (exp_r <= EXP_MIN) begin
         m2_res_d = {m1_sign_q, {(WIDTH-1){1'b0}}};
      end
      case (m1_spc_q)
         SPC_NAN:  m2_res_d = QNAN;
         SPC_INF:  m2_res_d = {m1_sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
         SPC_ZERO: m2_res_d = {m1_sign_q, {(WIDTH-1){1'b0}}};
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m2_vld_q <= 1'b0;
         m2_res_q <= '0;
      end else begin
         m2_vld_q <= m1_vld_q;
         m2_res_q <= m2_res_d;
      end
   end

   // Entries in delay line + M1 + M2; an entry leaves when M2 pushes it into the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= '0;
      end else begin
         inflight_q <= inflight_q + CW'(acc) - CW'(m2_vld_q);
      end
   end

   fp_div_fifo #(
      .DW    (WIDTH),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (m2_vld_q),
      .push_dat_i (m2_res_q),
      .pop_i      (out_ready),
      .vld_o      (out_valid),
      .dat_o      (q),
      .count_o    (fifo_cnt)
   );

endmodule

// File: tb/tb_fp_div_recip_mul.sv
// Self-checking bench for fp_div_recip_mul with a scoreboard of expected quotients.
// Latency: n/a (bench).
// Backpressure: drives out_ready low/high to exercise credits and result hold.
`timescale 1ns/1ps
module tb_fp_div_recip_mul;
   import fpu_div_pkg::*;

   localparam int L  = DEF_RECIP_LAT;
   localparam int D  = DEF_FIFO_DEPTH;
   localparam int NV = 17;
`ifdef FP_DIV_RNE_EN
   localparam logic [31:0] RND_EXP = 32'h3FC0_0002;
`else
   localparam logic [31:0] RND_EXP = 32'h3FC0_0001;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] div_o;
   logic [31:0] recip_i;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] q;

   logic [31:0] stub_r = '0;
   logic [31:0] pipe [L];
   logic [31:0] sb_q [$];
   string       sb_tag [$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          n_out = 0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_q = '0;

   // Vector table: dividend, divisor, forced reciprocal, expected quotient.
   logic [31:0] va [NV] = '{32'h3F800000, 32'h00000000, 32'hBF800000, 32'h00000000,
                            32'h7F800000, 32'h7FC00001, 32'h3F800000, 32'h3F800000,
                            32'hC0C00000, 32'h3FC00000, 32'h7F000000, 32'h00800000,
                            32'h7F800000, 32'h80000000, 32'h3F800001, 32'h00000001,
                            32'h3F800003};
   logic [31:0] vb [NV] = '{32'h40800000, 32'h40000000, 32'h00000000, 32'h00000000,
                            32'h7F800000, 32'h40000000, 32'hFFC00000, 32'h7F800000,
                            32'h40000000, 32'h3F2AAAAB, 32'h00800000, 32'h7F000000,
                            32'hC0000000, 32'h7F800000, 32'h3F800000, 32'h40000000,
                            32'h3F800000};
   logic [31:0] vr [NV] = '{32'h3E800000, 32'h3F000000, 32'h00000000, 32'h00000000,
                            32'h00000000, 32'h3F000000, 32'h00000000, 32'h00000000,
                            32'h3F000000, 32'h3FC00000, 32'h7F000000, 32'h00800000,
                            32'h00000000, 32'h00000000, 32'h3FC00000, 32'h3F000000,
                            32'h3FC00000};
   logic [31:0] vq [NV] = '{32'h3E800000, 32'h00000000, 32'hFF800000, 32'h7FC00000,
                            32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
                            32'hC0400000, 32'h40100000, 32'h7F800000, 32'h00000000,
                            32'hFF800000, 32'h80000000, RND_EXP,      32'h00000000,
                            32'h3FC00004};

   fp_div_recip_mul dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .div_o     (div_o),
      .recip_i   (recip_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reciprocal stage stand-in: returns the forced value RECIP_LAT edges after acceptance.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < L; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= (in_valid && in_ready) ? stub_r : 32'h0;
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign recip_i = pipe[L-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   // Output monitor: pops and compares on each handshake, checks hold stability.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("spurious_out", {31'b0, out_valid}, 32'h0);
            end else begin
               chk(sb_tag.pop_front(), q, sb_q.pop_front());
               n_out++;
            end
         end
         if (hold_v && out_valid) chk("hold_q", q, hold_q);
         hold_v = out_valid && !out_ready;
         hold_q = q;
      end else begin
         hold_v = 1'b0;
      end
   end

   // Presents a pair and holds it until accepted; returns before the accepting edge.
   task automatic send(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] tr, input logic [31:0] texp, input string tag);
      int w = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; a = ta; b = tb_v; stub_r = tr;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (in_ready) begin
         sb_q.push_back(texp);
         sb_tag.push_back(tag);
         #1 chk({tag, "_div_o"}, div_o, tb_v);
      end else begin
         chk("send_timeout", {31'b0, in_ready}, 32'h1);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0; a = '0; b = '0; stub_r = '0;
   endtask

   task automatic drain();
      int w = 0;
      while (sb_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", sb_q.size(), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int acc_cyc;
      int acc_n;
      int out0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_q", q, 32'h0);
      chk("rst_div_o", div_o, 32'h0);
      rst = 1'b0;
      out_ready = 1'b1;

      // First-result latency: 6.0 / 2.0 with reciprocal 0.5.
      send(32'h40C00000, 32'h40000000, 32'h3F000000, 32'h40400000, "div6_2");
      acc_cyc = cyc + 1;
      idle();
      begin
         int w = 0;
         while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
         end
      end
      chk("latency", cyc - acc_cyc, 32'd6);
      drain();

      // Back-to-back table of normal, special, range and rounding cases.
      for (int i = 0; i < NV; i++) send(va[i], vb[i], vr[i], vq[i], $sformatf("vec%0d", i));
      idle();
      drain();

      // Credit limit: consumer stalled, 20 attempts, exactly D accepted.
      out_ready = 1'b0;
      acc_n = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         a = 32'h3F800000 | k;
         b = 32'h40000000;
         stub_r = 32'h3F800000;
         #1;
         chk("credit_rdy", {31'b0, in_ready}, {31'b0, (acc_n < D)});
         if (in_ready) begin
            sb_q.push_back(32'h3F800000 | k);
            sb_tag.push_back($sformatf("bp%0d", k));
            acc_n++;
         end else begin
            chk("bp_div_o", div_o, 32'h0);
         end
      end
      idle();
      chk("bp_accepted", acc_n, D);
      repeat (10) @(posedge clk);
      #1;
      chk("bp_full_vld", {31'b0, out_valid}, 32'h1);
      chk("bp_full_rdy", {31'b0, in_ready}, 32'h0);
      out0 = n_out;
      out_ready = 1'b1;
      drain();
      chk("bp_results", n_out - out0, D);

      // Reset with 3 pairs in flight and 2 in the FIFO.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++)
         send(32'h3F800040 | k, 32'h40000000, 32'h3F800000, 32'h3F800040 | k, $sformatf("rs%0d", k));
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_vld", {31'b0, out_valid}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_mid_q", q, 32'h0);
      sb_q.delete();
      sb_tag.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
      repeat (15) @(negedge clk);
      chk("post_rst_no_out", {31'b0, out_valid}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
